// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: minimum ratio,
// ratio clamping and high-phase length helpers.
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  function automatic logic [31:0] clamp_div(input logic [31:0] n);
    if (n < 32'(DIV_MIN)) begin
      clamp_div = 32'(DIV_MIN);
    end else begin
      clamp_div = n;
    end
  endfunction

  // Even N: N/2; odd N: (N+1)/2 so the extra cycle lands in the high phase.
  function automatic logic [31:0] high_cnt(input logic [31:0] n);
    if (n[0]) begin
      high_cnt = (n + 32'd1) >> 1;
    end else begin
      high_cnt = n >> 1;
    end
  endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// Ratio staging for clk_divider_n: holds the pending ratio and swaps it into
// the active ratio only when the counter reports a safe point.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_div_n,
  input  logic             i_apply_ok,
  output logic [WIDTH-1:0] o_act_n,
  output logic [WIDTH-1:0] o_act_n_nxt,
  output logic             o_ack
);

  logic [WIDTH-1:0] r_act_n;
  logic [WIDTH-1:0] r_pend_n;
  logic             r_pend_v;
  logic             r_ack;
  logic             w_apply;

  assign w_apply     = i_apply_ok & r_pend_v;
  assign o_act_n_nxt = w_apply ? r_pend_n : r_act_n;
  assign o_act_n     = r_act_n;
  assign o_ack       = r_ack;

  // A load on the apply edge is staged after the older pending value is consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_act_n  <= WIDTH'(DEFAULT_DIV);
      r_pend_n <= WIDTH'(DIV_MIN);
      r_pend_v <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= w_apply;
      if (w_apply) begin
        r_act_n <= r_pend_n;
      end else begin
        r_act_n <= r_act_n;
      end
      if (i_load) begin
        r_pend_n <= WIDTH'(clamp_div(32'(i_div_n)));
        r_pend_v <= 1'b1;
      end else if (w_apply) begin
        r_pend_n <= r_pend_n;
        r_pend_v <= 1'b0;
      end else begin
        r_pend_n <= r_pend_n;
        r_pend_v <= r_pend_v;
      end
    end
  end

endmodule

// File: rtl/clk_divider_n.sv
// Run-time programmable clock divider with period-end tick and glitch-free
// ratio changes. Define ODD_DUTY50_EN for exact 50% duty on odd ratios.
module clk_divider_n
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_n,
  input  logic             div_load,
  output logic             div_ack,
  output logic             clk_div,
  output logic             tick
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_act_n;
  logic [WIDTH-1:0] w_n_nxt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_last;
  logic             w_apply_ok;
  logic             w_p_nxt;
  logic             r_p;
  logic             r_tick;

  assign w_last     = (r_cnt == (w_act_n - WIDTH'(1)));
  assign w_apply_ok = ~en | w_last;

  clk_div_cfg #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_cfg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (div_load),
    .i_div_n    (div_n),
    .i_apply_ok (w_apply_ok),
    .o_act_n    (w_act_n),
    .o_act_n_nxt(w_n_nxt),
    .o_ack      (div_ack)
  );

  // Idle parks the counter at the last count so enabling starts a full period.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!en) begin
      w_cnt_nxt = w_n_nxt - WIDTH'(1);
    end else if (w_last) begin
      w_cnt_nxt = WIDTH'(0);
    end else begin
      w_cnt_nxt = r_cnt + WIDTH'(1);
    end
  end

`ifdef ODD_DUTY50_EN
  logic r_q;
  logic r_odd;

  always_comb begin
    w_p_nxt = 1'b0;
    if (w_n_nxt[0]) begin
      w_p_nxt = (32'(w_cnt_nxt) < ((32'(w_n_nxt) - 32'd1) >> 1));
    end else begin
      w_p_nxt = (32'(w_cnt_nxt) < high_cnt(32'(w_n_nxt)));
    end
  end

  // Half-cycle extension of the high phase for odd ratios.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= 1'b0;
    end else begin
      r_q <= r_p;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_odd <= 1'b0;
    end else begin
      r_odd <= w_n_nxt[0];
    end
  end

  assign clk_div = r_p | (r_odd & r_q);
`else
  assign w_p_nxt = (32'(w_cnt_nxt) < high_cnt(32'(w_n_nxt)));
  assign clk_div = r_p;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= WIDTH'(DEFAULT_DIV - 1);
      r_p    <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (en) begin
        r_p    <= w_p_nxt;
        r_tick <= (w_cnt_nxt == (w_n_nxt - WIDTH'(1)));
      end else begin
        r_p    <= 1'b0;
        r_tick <= 1'b0;
      end
    end
  end

  assign tick = r_tick;

endmodule

// File: tb/tb_clk_divider_n.sv
// Randomised and directed checks of clk_divider_n against a period-position model.
module tb_clk_divider_n;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div_n = 8'd0;
  logic       div_load = 1'b0;
  logic       div_ack;
  logic       clk_div;
  logic       tick;

  int n_err = 0;
  int n_chk = 0;

  // Model: position inside the current period, active and pending ratio.
  int m_pos, m_act, m_pn, m_pv;
  logic m_ack, m_tick, m_p, m_prevp, m_clk;

  always #25 clk = ~clk;

  clk_divider_n #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .div_n(div_n), .div_load(div_load),
    .div_ack(div_ack), .clk_div(clk_div), .tick(tick)
  );

  task automatic model_reset();
    m_pos = 3; m_act = 4; m_pn = 2; m_pv = 0;
    m_ack = 0; m_tick = 0; m_p = 0; m_prevp = 0; m_clk = 0;
  endtask

  task automatic model_edge(input logic e, input logic ld, input int d);
    bit boundary;
    boundary = !e || (m_pos == m_act - 1);
    m_ack = boundary && (m_pv != 0);
    if (m_ack) begin m_act = m_pn; m_pv = 0; end
    if (ld) begin m_pn = (d < 2) ? 2 : d; m_pv = 1; end
    m_prevp = m_p;
    if (e) begin
      m_pos  = boundary ? 0 : m_pos + 1;
      m_tick = (m_pos == m_act - 1);
`ifdef ODD_DUTY50_EN
      m_p = (m_act % 2 == 1) ? (m_pos < (m_act - 1) / 2) : (m_pos < m_act / 2);
`else
      m_p = (m_pos < (m_act + 1) / 2);
`endif
    end else begin
      m_pos = m_act - 1; m_tick = 0; m_p = 0;
    end
`ifdef ODD_DUTY50_EN
    m_clk = m_p | ((m_act % 2 == 1) && m_prevp);
`else
    m_clk = m_p;
`endif
  endtask

  // Drive inputs, take one posedge, advance the model, settle for sampling.
  task automatic step(input logic e, input logic ld, input int d);
    en = e; div_load = ld; div_n = 8'(d);
    @(posedge clk);
    model_edge(e, ld, d);
    #1;
    div_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({clk_div, tick, div_ack} !== 3'b000) begin
      n_err++; $display("FAIL reset_out got=%b want=000", {clk_div, tick, div_ack});
    end
    rst = 1'b1;
  endtask

  task automatic test_n4();
    logic [3:0] pat;
    pat = 4'b1100;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 0);
      n_chk++;
      if (clk_div !== pat[3 - (i % 4)] || tick !== (i % 4 == 3)) begin
        n_err++; $display("FAIL n4_pattern cyc=%0d got clk_div=%b tick=%b", i, clk_div, tick);
      end
    end
  endtask

  task automatic test_load6();
    logic [5:0] pat;
    bit seen;
    pat = 6'b111000;
    seen = 0;
    step(1'b1, 1'b1, 6);
    for (int i = 0; i < 8 && !seen; i++) begin
      step(1'b1, 1'b0, 0);
      seen = (div_ack === 1'b1);
    end
    n_chk++;
    if (!seen) begin n_err++; $display("FAIL load6_ack got=0 want=1"); end
    for (int i = 0; i < 12; i++) begin
      n_chk++;
      if (clk_div !== pat[5 - (i % 6)] || tick !== (i % 6 == 5)) begin
        n_err++; $display("FAIL load6_pattern cyc=%0d got clk_div=%b tick=%b", i, clk_div, tick);
      end
      step(1'b1, 1'b0, 0);
    end
  endtask

  task automatic test_odd5();
    int start;
    step(1'b1, 1'b1, 5);
    start = -1;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, 0);
      n_chk++;
      if ({clk_div, tick, div_ack} !== {m_clk, m_tick, m_ack}) begin
        n_err++; $display("FAIL odd5 got=%b want=%b", {clk_div, tick, div_ack}, {m_clk, m_tick, m_ack});
      end
`ifndef ODD_DUTY50_EN
      if (start < 0 && div_ack === 1'b1) start = i;
      if (start >= 0) begin
        n_chk++;
        if (clk_div !== ((i - start) % 5 < 3)) begin
          n_err++; $display("FAIL odd5_duty cyc=%0d got=%b", i - start, clk_div);
        end
      end
`else
      @(negedge clk); #1;
      n_chk++;
      if (clk_div !== m_p) begin
        n_err++; $display("FAIL odd5_negedge got=%b want=%b", clk_div, m_p);
      end
      @(posedge clk); #1;
      m_prevp = m_p;
      model_edge(1'b1, 1'b0, 0);
`endif
    end
  endtask

  task automatic test_clamp();
    for (int v = 0; v < 2; v++) begin
      step(1'b1, 1'b1, v);
      for (int i = 0; i < 10; i++) begin
        step(1'b1, 1'b0, 0);
        n_chk++;
        if ({clk_div, tick, div_ack} !== {m_clk, m_tick, m_ack}) begin
          n_err++; $display("FAIL clamp%0d got=%b want=%b", v, {clk_div, tick, div_ack}, {m_clk, m_tick, m_ack});
        end
      end
      n_chk++;
      if (m_act != 2 || clk_div === clk_div_prev_dummy(clk_div)) begin
        n_err++; $display("FAIL clamp%0d_toggle act=%0d", v, m_act);
      end
    end
  endtask

  // Value the output must take on the following cycle when ratio is 2.
  function automatic logic clk_div_prev_dummy(input logic c);
    return ~c;
  endfunction

  task automatic test_last_write();
    int acks;
    int guard;
    acks = 0;
    guard = 0;
    while (m_pos == m_act - 1 && guard < 4) begin step(1'b1, 1'b0, 0); guard++; end
    step(1'b1, 1'b1, 8);
    step(1'b1, 1'b1, 3);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 0);
      if (div_ack === 1'b1) acks++;
      n_chk++;
      if ({clk_div, tick, div_ack} !== {m_clk, m_tick, m_ack}) begin
        n_err++; $display("FAIL last_write got=%b want=%b", {clk_div, tick, div_ack}, {m_clk, m_tick, m_ack});
      end
    end
    n_chk++;
    if (acks != 1 || m_act != 3) begin
      n_err++; $display("FAIL last_write_acks got=%0d want=1", acks);
    end
  endtask

  task automatic test_boundary_load();
    int guard;
    int since;
    guard = 0;
    while (m_pos != m_act - 2 && guard < 10) begin step(1'b1, 1'b0, 0); guard++; end
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 5);
    since = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 0);
      if (div_ack === 1'b1 && since < 0) since = i + 1;
    end
    n_chk++;
    if (since != 3) begin
      n_err++; $display("FAIL boundary_load ack_after=%0d want=3", since);
    end
  endtask

  task automatic test_disable();
    bit ack_seen;
    int guard;
    guard = 0;
    ack_seen = 0;
    while (!(m_pos == 0) && guard < 10) begin step(1'b1, 1'b0, 0); guard++; end
    step(1'b0, 1'b0, 0);
    n_chk++;
    if (tick !== 1'b0 || div_ack !== 1'b0) begin
      n_err++; $display("FAIL disable_out got tick=%b ack=%b want 0 0", tick, div_ack);
    end
    step(1'b0, 1'b1, 7);
    step(1'b0, 1'b0, 0);
    ack_seen = (div_ack === 1'b1);
    n_chk++;
    if (!ack_seen || clk_div !== 1'b0) begin
      n_err++; $display("FAIL disable_load7 ack=%b clk_div=%b", div_ack, clk_div);
    end
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b0, 0);
      n_chk++;
      if (clk_div !== (i % 7 < 4) || tick !== (i % 7 == 6)) begin
        n_err++; $display("FAIL enable_n7 cyc=%0d got clk_div=%b tick=%b", i, clk_div, tick);
      end
    end
  endtask

  task automatic test_midreset();
    step(1'b1, 1'b1, 9);
    step(1'b1, 1'b0, 0);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({clk_div, tick, div_ack} !== 3'b000) begin
      n_err++; $display("FAIL midreset_out got=%b want=000", {clk_div, tick, div_ack});
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 0);
      n_chk++;
      if (clk_div !== (i % 4 < 2) || tick !== (i % 4 == 3) || div_ack !== 1'b0) begin
        n_err++; $display("FAIL midreset_n4 cyc=%0d got=%b", i, {clk_div, tick, div_ack});
      end
    end
  endtask

  task automatic test_random();
    logic e, ld;
    int d;
    for (int i = 0; i < 400; i++) begin
      e  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 9) == 0);
      d  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      step(e, ld, d);
      n_chk++;
      if ({clk_div, tick, div_ack} !== {m_clk, m_tick, m_ack}) begin
        n_err++; $display("FAIL random cyc=%0d got=%b want=%b", i, {clk_div, tick, div_ack}, {m_clk, m_tick, m_ack});
      end
    end
  endtask

  initial begin
    test_reset();
    test_n4();
    test_load6();
    test_odd5();
    test_clamp();
    test_last_write();
    test_boundary_load();
    test_disable();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
